// File: rtl/xxd_line_formatter.sv
// Buffers one line of input bytes, then streams its xxd-style ASCII rendering
// (offset, grouped hex, printable column, newline) one character per transfer.
module xxd_line_formatter #(
  parameter int BPL        = 16,
  parameter int GROUP      = 2,
  parameter int OFS_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eol
);

  localparam int OW   = 4 * OFS_DIGITS;
  localparam int NSW  = $clog2(OW);
  localparam int CW   = $clog2(BPL) + 1;
  localparam int SW   = $clog2(BPL);
  localparam int IMAX = (BPL > OFS_DIGITS) ? BPL : OFS_DIGITS;
  localparam int IW   = $clog2(IMAX);

  // Each emit state names the character currently held in out_data_q.
  typedef enum logic [3:0] {
    S_FILL, S_LOAD, S_OFS, S_COLON, S_SPACE, S_HEX, S_GSEP, S_GAP, S_ASC, S_EOL
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   nib_q, nib_d;
  logic                   last_q, last_d;
  logic [OW-1:0]          ofs_q, ofs_d;
  logic [BPL-1:0][7:0]    buf_q, buf_d;
  logic [7:0]             out_data_q, out_data_d;

  logic                   emit;
  logic                   xfer;
  logic [7:0]             byte_sel;
  logic [3:0]             ofs_nib;
  logic [NSW-1:0]         nsel;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction

  assign emit = (state_q != S_FILL) && (state_q != S_LOAD);
  assign xfer = emit && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nib_d   = nib_q;
    last_d  = last_q;
    ofs_d   = ofs_q;
    buf_d   = buf_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_d[cnt_q[SW-1:0]] = in_data;
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q == CW'(BPL - 1)) || in_last) begin
            state_d = S_LOAD;
            last_d  = in_last;
          end
        end
      end
      S_LOAD: begin
        state_d = S_OFS;
        idx_d   = '0;
      end
      S_OFS: if (xfer) begin
        if (idx_q == IW'(OFS_DIGITS - 1)) state_d = S_COLON;
        else                               idx_d   = idx_q + IW'(1);
      end
      S_COLON: if (xfer) state_d = S_SPACE;
      S_SPACE: if (xfer) begin
        state_d = S_HEX;
        idx_d   = '0;
        nib_d   = 1'b0;
      end
      S_HEX: if (xfer) begin
        if (!nib_q) begin
          nib_d = 1'b1;
        end else if ((int'(idx_q) % GROUP) == (GROUP - 1)) begin
          state_d = S_GSEP;
        end else begin
          idx_d = idx_q + IW'(1);
          nib_d = 1'b0;
        end
      end
      S_GSEP: if (xfer) begin
        if (idx_q == IW'(BPL - 1)) begin
          state_d = S_GAP;
        end else begin
          state_d = S_HEX;
          idx_d   = idx_q + IW'(1);
          nib_d   = 1'b0;
        end
      end
      S_GAP: if (xfer) begin
        state_d = S_ASC;
        idx_d   = '0;
      end
      S_ASC: if (xfer) begin
        if (int'(idx_q) == int'(cnt_q) - 1) state_d = S_EOL;
        else                                 idx_d   = idx_q + IW'(1);
      end
      S_EOL: if (xfer) begin
        state_d = S_FILL;
        cnt_d   = '0;
        idx_d   = '0;
        ofs_d   = last_q ? '0 : (ofs_q + OW'(cnt_q));
      end
      default: state_d = S_FILL;
    endcase
  end

  // Next character is rendered from the next-state position so the output is registered.
  always_comb begin
    byte_sel   = buf_q[idx_d[SW-1:0]];
    nsel       = NSW'((OFS_DIGITS - 1 - int'(idx_d)) * 4);
    ofs_nib    = ofs_q[nsel +: 4];
    out_data_d = 8'h00;
    case (state_d)
      S_OFS:   out_data_d = hex_char(ofs_nib);
      S_COLON: out_data_d = 8'h3A;
      S_SPACE,
      S_GSEP,
      S_GAP:   out_data_d = 8'h20;
      S_HEX: begin
        if (int'(idx_d) < int'(cnt_q))
          out_data_d = hex_char(nib_d ? byte_sel[3:0] : byte_sel[7:4]);
        else
          out_data_d = 8'h20;
      end
      S_ASC:   out_data_d = ((byte_sel >= 8'h20) && (byte_sel <= 8'h7E)) ? byte_sel : 8'h2E;
      S_EOL:   out_data_d = 8'h0A;
      default: out_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      idx_q      <= '0;
      nib_q      <= 1'b0;
      last_q     <= 1'b0;
      ofs_q      <= '0;
      buf_q      <= '0;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      nib_q      <= nib_d;
      last_q     <= last_d;
      ofs_q      <= ofs_d;
      buf_q      <= buf_d;
      out_data_q <= out_data_d;
    end
  end

  // Outputs are masked during the reset cycle so a line being emitted stops at once.
  assign in_ready  = rst_n && (state_q == S_FILL);
  assign out_valid = rst_n && emit;
  assign out_eol   = rst_n && (state_q == S_EOL);
  assign out_data  = rst_n ? out_data_q : 8'h00;

endmodule

// File: tb/tb_xxd_line_formatter.sv
// Directed bench for xxd_line_formatter; newline characters are shown as '|'.
module tb_xxd_line_formatter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_eol;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xxd_line_formatter #(.BPL(16), .GROUP(2), .OFS_DIGITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_eol  (out_eol)
  );

  task automatic chk(input string tag, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", tag, got, exp);
    end
  endtask

  function automatic string num(input int v);
    return $sformatf("%0d", v);
  endfunction

  function automatic string sp(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  // Feeds d (in_last on final byte if lastflag) and collects characters until
  // nlines newlines arrive, or until stop_after characters when stop_after>0.
  task automatic run(input string tag, input logic [7:0] d[$], input bit lastflag,
                     input int rmode, input bit bubbles, input int nlines,
                     input int stop_after, output string s, output int cyc);
    int fi = 0, eols = 0, stab = 0, eolbad = 0, rdybad = 0;
    bit hold = 1'b0, done = 1'b0;
    logic [7:0] hold_d = 8'h00;
    string c;
    s = "";
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      if (hold && !(out_valid && out_data == hold_d)) stab++;
      if (out_valid && in_ready) rdybad++;
      if (out_valid && (out_eol != (out_data == 8'h0A))) eolbad++;
      if (fi < d.size() && (!bubbles || (cyc % 2) == 0)) begin
        in_valid = 1'b1;
        in_data  = d[fi];
        in_last  = lastflag && (fi == d.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        in_last  = 1'b1;
      end
      out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (in_valid && in_ready) fi++;
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        if (out_data == 8'h0A) c = "|";
        else                   c = $sformatf("%c", out_data);
        s = {s, c};
        if (out_eol) eols++;
      end
      cyc++;
      if (fi == d.size() && eols == nlines) done = 1'b1;
      if (stop_after > 0 && s.len() == stop_after) done = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk({tag, "_timeout"}, "expired", "done");
    chk({tag, "_stable"}, num(stab), "0");
    chk({tag, "_eolflag"}, num(eolbad), "0");
    chk({tag, "_rdy_in_emit"}, num(rdybad), "0");
    if (stop_after == 0) chk({tag, "_lines"}, num(eols), num(nlines));
  endtask

  initial begin
    logic [7:0] q1[$], q2[$], q3[$], q4[$], q5[$];
    string s, e1, e2, e3, e4, e5;
    int cyc;

    for (int i = 0; i < 16; i++) q1.push_back(8'(i));
    q2 = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h0a};
    for (int i = 0; i < 20; i++) q3.push_back(8'h41);
    q4 = '{8'h1f, 8'h20, 8'h7e, 8'h7f, 8'h80, 8'hff};
    q5 = '{8'h5a};

    e1 = "00000000: 0001 0203 0405 0607 0809 0a0b 0c0d 0e0f  ................|";
    e2 = {"00000000: 4865 6c6c 6f0a", sp(27), "Hello.|"};
    e3 = {"00000000: 4141 4141 4141 4141 4141 4141 4141 4141  AAAAAAAAAAAAAAAA|",
          "00000010: 4141 4141", sp(32), "AAAA|"};
    e4 = {"00000000: 1f20 7e7f 80ff", sp(27), ". ~...|"};
    e5 = {"00000000: 5a", sp(39), "Z|"};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", num(int'(in_ready)), "0");
    chk("rst_out_valid", num(int'(out_valid)), "0");
    chk("rst_out_eol", num(int'(out_eol)), "0");
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", num(int'(in_ready)), "1");
    chk("post_rst_out_data", num(int'(out_data)), "0");
    chk("post_rst_out_valid", num(int'(out_valid)), "0");

    // full line, sink always ready
    run("t1", q1, 1'b1, 0, 1'b0, 1, 0, s, cyc);
    chk("t1_text", s, e1);
    chk("t1_len", num(s.len()), "68");
    chk("t1_cycles", num(cyc), "85");
    @(negedge clk);
    chk("t1_ready_after", num(int'(in_ready)), "1");

    // partial line, offset restarts after in_last
    run("t2", q2, 1'b1, 0, 1'b0, 1, 0, s, cyc);
    chk("t2_text", s, e2);

    // two lines, offset advance
    run("t3", q3, 1'b1, 0, 1'b0, 2, 0, s, cyc);
    chk("t3_text", s, e3);

    // printable boundaries, input bubbles carrying stray in_last
    run("t4", q4, 1'b1, 0, 1'b1, 1, 0, s, cyc);
    chk("t4_text", s, e4);

    // backpressure
    run("t5", q1, 1'b1, 1, 1'b0, 1, 0, s, cyc);
    chk("t5_text", s, e1);

    // reset mid-emission
    run("t6", q1, 1'b1, 0, 1'b0, 1, 30, s, cyc);
    chk("t6_pre", s, e1.substr(0, 29));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", num(int'(out_valid)), "0");
    chk("t6_rst_in_ready", num(int'(in_ready)), "0");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_after_in_ready", num(int'(in_ready)), "1");
    chk("t6_after_out_valid", num(int'(out_valid)), "0");
    run("t6b", q5, 1'b1, 0, 1'b0, 1, 0, s, cyc);
    chk("t6b_text", s, e5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
